// File: rtl/seg7_capture.sv
// Debounced capture of a multiplexed active-low seven-segment bus: each stable
// (segment, anode) window is decoded once into a per-position BCD digit.
module seg7_capture #(
    parameter int NDIG       = 4,
    parameter int STABLE_CYC = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          seg,
    input  logic [NDIG-1:0]     an,
    input  logic                err_clr,
    output logic [4*NDIG-1:0]   digits,
    output logic [NDIG-1:0]     blank,
    output logic [NDIG-1:0]     valid_mask,
    output logic                frame_valid,
    output logic                err
);

    localparam int SW = 8 + NDIG;
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

    logic [SW-1:0]   sample, s_q;
    logic [7:0]      cnt;
    logic            same, cap;
    logic [NDIG-1:0] an_q;
    logic [6:0]      seg_q;

    assign sample = {seg, an};
    assign same   = (sample == s_q);
    // One event per stable window: only the step from STABLE_CYC-1 to STABLE_CYC fires.
    assign cap    = same && (cnt == 8'(STABLE_CYC - 1));
    assign an_q   = s_q[NDIG-1:0];
    assign seg_q  = s_q[NDIG+6:NDIG];

    logic [3:0]    nzero;
    logic [IW-1:0] idx;

    // NOTE: every signal driven here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        nzero = 4'd0;
        idx   = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (!an_q[i]) begin
                nzero = nzero + 4'd1;
                idx   = IW'(i);
            end
        end
    end

    logic       pat_ok, pat_blank;
    logic [3:0] bcd;

    always_comb begin
        pat_ok    = 1'b1;
        pat_blank = 1'b0;
        bcd       = 4'd0;
        case (seg_q)
            7'h40: bcd = 4'd0;
            7'h79: bcd = 4'd1;
            7'h24: bcd = 4'd2;
            7'h30: bcd = 4'd3;
            7'h19: bcd = 4'd4;
            7'h12: bcd = 4'd5;
            7'h02: bcd = 4'd6;
            7'h78: bcd = 4'd7;
            7'h00: bcd = 4'd8;
            7'h18: bcd = 4'd9;
            7'h7F: pat_blank = 1'b1;
            default: pat_ok = 1'b0;
        endcase
    end

    logic            legal_cap, err_evt;
    logic [NDIG-1:0] new_mask;

    assign legal_cap = cap && (nzero == 4'd1) && pat_ok;
    assign err_evt   = cap && ((nzero > 4'd1) || ((nzero == 4'd1) && !pat_ok));
    assign new_mask  = valid_mask | (NDIG'(1) << idx);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_q         <= '1;
            cnt         <= 8'd0;
            digits      <= '0;
            blank       <= '1;
            valid_mask  <= '0;
            frame_valid <= 1'b0;
            err         <= 1'b0;
        end else begin
            s_q         <= sample;
            frame_valid <= 1'b0;
            if (!same)
                cnt <= 8'd0;
            else if (cnt != 8'(STABLE_CYC))
                cnt <= cnt + 8'd1;

            if (legal_cap) begin
                digits[4*idx +: 4] <= pat_blank ? 4'd0 : bcd;
                blank[idx]         <= pat_blank;
                if (&new_mask) begin
                    valid_mask  <= '0;
                    frame_valid <= 1'b1;
                end else begin
                    valid_mask <= new_mask;
                end
            end

            // A new error event outranks a simultaneous clear.
            err <= err_evt | (err & ~err_clr);
        end
    end

endmodule

// File: tb/tb_seg7_capture.sv
// Randomized and directed bench for seg7_capture: a run-length reference model
// predicts the outputs after every edge and a monitor compares them each cycle.
module tb_seg7_capture;

    localparam int NDIG   = 4;
    localparam int STABLE = 4;

    typedef struct packed {
        logic [15:0] digits;
        logic [3:0]  blank;
        logic [3:0]  mask;
        logic        fv;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  seg = 8'hFF;
    logic [3:0]  an = 4'hF;
    logic        err_clr = 1'b0;
    logic [15:0] digits;
    logic [3:0]  blank, valid_mask;
    logic        frame_valid, err;

    seg7_capture #(.NDIG(NDIG), .STABLE_CYC(STABLE)) dut (
        .clk(clk), .rst(rst), .seg(seg), .an(an), .err_clr(err_clr),
        .digits(digits), .blank(blank), .valid_mask(valid_mask),
        .frame_valid(frame_valid), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int fv_cnt = 0;
    exp_t q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: registered outputs are presented every cycle; compare at negedge.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check("digits", 32'(digits), 32'(e.digits));
            check("blank", 32'(blank), 32'(e.blank));
            check("valid_mask", 32'(valid_mask), 32'(e.mask));
            check("frame_valid", 32'(frame_valid), 32'(e.fv));
            check("err", 32'(err), 32'(e.err));
            if (frame_valid === 1'b1) fv_cnt++;
        end
    end

    // Reference model: display state plus the run length of identical samples.
    logic [6:0]  pats [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h18};
    int          m_dig [NDIG];
    logic [3:0]  m_blank, m_mask;
    logic        m_fv, m_err;
    logic [11:0] m_prev;
    int          m_run;

    task automatic model_edge(input logic [7:0] s, input logic [3:0] a,
                              input logic c, input logic r);
        exp_t e;
        logic evt_err;
        int   zeros, pos, val;
        if (r) begin
            foreach (m_dig[i]) m_dig[i] = 0;
            m_blank = 4'hF;
            m_mask  = 4'h0;
            m_fv    = 1'b0;
            m_err   = 1'b0;
            m_prev  = 12'hFFF;
            m_run   = 1;
        end else begin
            if ({s, a} == m_prev) m_run++;
            else begin
                m_prev = {s, a};
                m_run  = 1;
            end
            m_fv    = 1'b0;
            evt_err = 1'b0;
            // The (STABLE+1)-th identical consecutive sample is the capture point.
            if (m_run == STABLE + 1) begin
                zeros = $countones(~a);
                if (zeros > 1) evt_err = 1'b1;
                else if (zeros == 1) begin
                    pos = 0;
                    for (int i = 0; i < NDIG; i++) if (!a[i]) pos = i;
                    val = -1;
                    for (int d = 0; d < 10; d++) if (pats[d] == s[6:0]) val = d;
                    if (val < 0 && s[6:0] != 7'h7F) evt_err = 1'b1;
                    else begin
                        m_dig[pos]   = (val < 0) ? 0 : val;
                        m_blank[pos] = (val < 0);
                        m_mask[pos]  = 1'b1;
                        if (m_mask == 4'hF) begin
                            m_mask = 4'h0;
                            m_fv   = 1'b1;
                        end
                    end
                end
            end
            m_err = evt_err || (m_err && !c);
        end
        for (int i = 0; i < NDIG; i++) e.digits[4*i +: 4] = 4'(m_dig[i]);
        e.blank = m_blank;
        e.mask  = m_mask;
        e.fv    = m_fv;
        e.err   = m_err;
        q.push_back(e);
    endtask

    task automatic step(input logic [7:0] s, input logic [3:0] a,
                        input logic c, input logic r);
        @(negedge clk);
        #1;
        seg     = s;
        an      = a;
        err_clr = c;
        rst     = r;
        model_edge(s, a, c, r);
    endtask

    task automatic hold(input logic [7:0] s, input logic [3:0] a, input int n,
                        input logic c = 1'b0);
        for (int k = 0; k < n; k++) step(s, a, c, 1'b0);
    endtask

    int fv_base;

    initial begin
        // Reset with arbitrary inputs
        for (int k = 0; k < 3; k++) step(8'($urandom), 4'($urandom), 1'($urandom), 1'b1);
        hold(8'hFF, 4'hF, 2);

        hold(8'hA4, 4'b1110, 8);

        fv_base = fv_cnt;
        hold(8'hF9, 4'b1110, 8);
        hold(8'hA4, 4'b1101, 8);
        hold(8'hB0, 4'b1011, 8);
        hold(8'h99, 4'b0111, 8);
        hold(8'hFF, 4'hF, 2);
        check("scan_frame_pulses", 32'(fv_cnt - fv_base), 32'd1);

        // Glitch shorter than the window, then a held digit
        hold(8'hC0, 4'b1101, 3);
        hold(8'h92, 4'b1101, 8);

        // Illegal pattern, lone clear, clear coinciding with a new error
        hold(8'hAA, 4'b1011, 8);
        hold(8'hFF, 4'hF, 1, 1'b1);
        hold(8'hFF, 4'hF, 2);
        hold(8'hAA, 4'b1011, 8);
        hold(8'hFF, 4'hF, 1, 1'b1);
        hold(8'hAA, 4'b1011, 8, 1'b1);
        hold(8'hFF, 4'hF, 1, 1'b1);

        hold(8'h7F, 4'b1101, 8);
        hold(8'hA4, 4'b1100, 8);

        // Reset mid-window with inputs held throughout
        hold(8'h99, 4'b1110, 2);
        step(8'h99, 4'b1110, 1'b0, 1'b1);
        step(8'h99, 4'b1110, 1'b0, 1'b1);
        hold(8'h99, 4'b1110, 8);

        for (int it = 0; it < 400; it++) begin
            int         kind, len;
            logic [7:0] s;
            logic [3:0] a;
            kind = $urandom_range(0, 11);
            a    = ~(4'b0001 << $urandom_range(0, 3));
            s    = {1'($urandom), pats[$urandom_range(0, 9)]};
            if (kind == 6) s = {1'($urandom), 7'h7F};
            else if (kind == 7) s = 8'($urandom);
            else if (kind == 8) begin
                a = 4'($urandom);
                while ($countones(~a) < 2) a = 4'($urandom);
            end else if (kind == 9) a = 4'hF;
            len = $urandom_range(1, 9);
            for (int k = 0; k < len; k++)
                step(s, a, ($urandom_range(0, 7) == 0), ($urandom_range(0, 199) == 0));
        end

        hold(8'hFF, 4'hF, 3);
        @(negedge clk);
        @(negedge clk);
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_capture.md
# seg7_capture

Scan-side decoder for the multiplexed seven-segment display bus used by the traffic-light display path. The block samples the active-low segment lines and active-low digit anodes, debounces each (segment, anode) pair, and decodes the lit pattern back to a BCD digit per display position. It raises a one-cycle frame pulse once every position has been captured. The block is used as an on-chip monitor and as a self-check in display-path benches.

## Interface
- NDIG, default 4: number of multiplexed digit positions (1..8).
- STABLE_CYC, default 4: consecutive identical samples required before capture (2..255).
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- seg  in  8  active-low segments; bit7 = dp, bits 6:0 = {g,f,e,d,c,b,a}.
- an  in  NDIG  active-low digit enables; one zero selects one digit.
- err_clr  in  1  clears the sticky error flag.
- digits  out  4*NDIG  captured BCD values; digit i occupies [4i+3:4i].
- blank  out  NDIG  bit i = digit i was last captured dark.
- valid_mask  out  NDIG  bit i = digit i captured since the last frame pulse.
- frame_valid  out  1  one-cycle pulse; all positions captured.
- err  out  1  sticky flag for an illegal pattern or a non-one-hot anode.

## Operation
- Input register: the block samples {seg, an} every cycle into s_q. Decoding ignores dp (seg[7]).
- Stability counter cnt:
  - cnt clears to 0 when the new sample differs from s_q.
  - Otherwise cnt increments, saturating at STABLE_CYC.
  - A capture event fires only on the edge where cnt goes from STABLE_CYC-1 to STABLE_CYC, so there is exactly one event per stable window.
- Capture event, evaluated on the anode value in s_q:
  - All ones (no digit driven): no action, no error.
  - Exactly one zero at index i: decode seg[6:0] as below.
  - More than one zero: set err; digits, blank and valid_mask are unchanged.
- Decode table for seg[6:0] (hex):
  - 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7, 00→8, 18→9.
  - 7F → blank: digit i is written 0 and blank[i] is set.
  - On a legal digit, blank[i] is cleared.
  - Any other pattern: set err; digit i, blank[i] and valid_mask[i] are unchanged.
- On a legal or blank capture, valid_mask[i] is set.
- Frame completion:
  - If the capture makes valid_mask all ones, then on that same edge frame_valid goes to 1 and valid_mask clears to 0.
  - frame_valid returns to 0 on the next edge.
  - Re-capturing an already-set position does not pulse frame_valid.
- Error flag:
  - err is set by an error event and cleared by err_clr.
  - If an error event and err_clr occur in the same cycle, set wins.
- Reset values:
  - digits = 0, blank = all ones, valid_mask = 0, frame_valid = 0, err = 0.
  - cnt = 0, s_q = all ones (seg = 8'hFF, an = all ones).
  - Reset asserted mid-window discards the partial count; counting restarts from the first post-reset sample.

## Timing
- Inputs stable from the cycle before edge k: s_q loads at edge k, with cnt = 0.
- Outputs update at edge k+STABLE_CYC (5 edges for the default).
- Any input change restarts the window. Patterns held for fewer than STABLE_CYC+1 sampled cycles are never captured.
- Holding an input indefinitely produces one capture only.
- frame_valid is registered and coincident with the digits update that completes the frame.
- All outputs are registered; there are no combinational input-to-output paths.
- Throughput: at most one capture per STABLE_CYC+1 cycles.

## Test plan
- Reset: hold rst 3 cycles with arbitrary inputs → digits = 16'h0000, blank = 4'hF, valid_mask = 0, frame_valid = 0, err = 0.
- Single digit: an = 4'b1110, seg = 8'hA4, held 8 cycles:
  - digits[3:0] = 2 and valid_mask = 4'b0001 exactly 5 edges after the first sample.
  - blank = 4'b1110; frame_valid stays 0.
- Full scan: drive digits 0..3 as 1, 2, 3, 4 (seg = F9, A4, B0, 99), 8 cycles each:
  - digits = 16'h4321.
  - frame_valid pulses exactly once, on the digit-3 capture edge; valid_mask = 0 in that cycle.
- Glitch: an = 4'b1101, seg = 8'hC0 for 3 cycles, then seg = 8'h92 held → digits[7:4] = 5, never 0; only one capture.
- Errors:
  - seg = 8'hAA held on digit 2 → err = 1; digits[11:8] and valid_mask[2] unchanged.
  - err_clr pulsed alone → err = 0.
  - err_clr asserted on the same edge as a new error event → err stays 1.
- Blank and anode check:
  - seg = 8'h7F on digit 1 → blank[1] = 1, digits[7:4] = 0, valid_mask[1] = 1.
  - an = 4'b1100 held → err = 1, no register update.
  - Reset asserted mid-window, then inputs held → capture occurs 5 edges after reset deasserts.
